plic_gateway_ctrl: RTL and testbench
====================================

Name: plic_gateway_ctrl

Overview:
Per-source interrupt gateways plus per-target claim/complete sequencing for the PLIC.
- Turns level-sensitive external interrupt lines into single pending requests.
- Tracks which sources are in service and which target owns each one.
- Selects the highest-priority eligible source per target and drives the per-target interrupt lines to the harts.
- Sits between the PLIC register block (claim/complete/config) and the interrupt sources.

Parameters:
SRC_N, 31, number of interrupt sources (IDs 1..SRC_N, max 31; ID 0 reserved)
TGT_N, 2, number of targets (hart contexts, max 32)
PRIO_W, 3, priority field width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
irq_src  input  [SRC_N:1]  level-sensitive source lines, already synchronized to clk
claim_valid  input  1  claim read strobe (one cycle per APB access)
claim_tgt  input  5  target addressed by the claim register
complete_valid  input  1  complete write strobe
complete_src  input  5  source ID written to complete
complete_tgt  input  5  target addressed by the complete write
cfg_int_prio  input  [SRC_N:0][PRIO_W-1:0]  per-source priority (source 0 is 0)
cfg_int_enable  input  [TGT_N-1:0][SRC_N:0]  per-target enable (bit 0 is 0)
cfg_threshold  input  [TGT_N-1:0][PRIO_W-1:0]  per-target threshold
int_pending  output  [SRC_N:0]  pending bits; bit 0 always 0
claim_src  output  5  ID returned for a claim on claim_tgt; 0 = none
irq_tgt  output  [TGT_N-1:0]  interrupt request to each target

Behaviour:
- Reset (async, rst_n=0):
  - all gateways IDLE, int_pending=0, owner registers=0.
  - best_id[*]=0, best_prio[*]=0, irq_tgt=0.
- Gateway FSM per source i; states IDLE, PENDING, IN_SERVICE:
  - IDLE: irq_src[i]=1 -> PENDING next cycle; int_pending[i] rises with the state.
  - PENDING: int_pending[i]=1. Deassertion of irq_src[i] does not clear it.
    - Leaves on claim_valid & claim_src==i -> IN_SERVICE; owner[i]<=claim_tgt.
  - IN_SERVICE: int_pending[i]=0; the gate is closed, so irq_src[i] is ignored.
    - complete_valid & complete_src==i & complete_tgt==owner[i] & cfg_int_enable[complete_tgt][i] -> IDLE.
    - Any other complete is silently ignored.
  - IDLE entered with irq_src[i] still high -> PENDING one cycle later, so re-arming takes 2 cycles from the complete.
- Selection (registered, 1-cycle latency from int_pending/config):
  - eligible[t][i] = int_pending[i] & cfg_int_enable[t][i] & (cfg_int_prio[i]!=0).
  - best_id[t] = eligible source with highest priority; ties go to the lowest ID; 0 if none.
  - best_prio[t] = priority of best_id[t]; 0 if none.
  - irq_tgt[t] <= (max eligible priority > cfg_threshold[t]), registered in the same cycle as best_id.
- Claim:
  - claim_src = best_id[claim_tgt] if int_pending[best_id[claim_tgt]]=1, else 0. Combinational from registers.
  - This check covers a stale best_id (source already claimed by another target in the previous cycle). Such a claim returns 0 and changes no state.
  - claim_tgt >= TGT_N -> claim_src=0, no action.
  - irq_tgt[t] may stay high for 1 cycle after a claim; this is accepted.
- Complete with complete_src==0, complete_src>SRC_N or complete_tgt>=TGT_N -> ignored.
- claim_valid and complete_valid are mutually exclusive, because the register file has a single APB port. The bench asserts this; the RTL is not required to handle both.
- Threshold or enable changes take effect on irq_tgt one cycle later.
- Priority 0 masks a source from selection but not from gateway pending.

Decomposition:
- Package plic_pkg:
  - PLIC_ID_W=5, PLIC_MAX_SRC=31, PLIC_MAX_TGT=32.
  - typedef plic_id_t (logic [4:0]).
  - enum gw_state_e {GW_IDLE, GW_PENDING, GW_IN_SERVICE}.
- Sub-module plic_gateway: one source's FSM plus owner register; generated SRC_N times.
  - Inputs: irq, claim_hit, complete_hit.
  - Outputs: pending.
- Top level contains the per-target priority selection (loop or tree), the best_id/best_prio/irq_tgt flops and the claim_src mux.

Test Plan:
- SRC_N=31, TGT_N=2. Source 5, prio 3, enabled on tgt0, threshold 0. Pulse irq_src[5] for 1 cycle -> int_pending[5]=1 after 1 cycle and stays high after deassert; irq_tgt[0]=1 one cycle later; irq_tgt[1]=0.
- Sources 3 (prio 2) and 7 (prio 2) pending, plus source 9 (prio 1); all enabled on tgt0 -> claim returns 3, then 7, then 9. Each claimed source's pending bit clears next cycle.
- Source 4 (prio 1), threshold[0]=1 -> irq_tgt[0]=0 while claim_src still reads 4. Write threshold 0 -> irq_tgt[0]=1 one cycle later.
- Source 6 enabled on both targets. Claim from tgt0 returns 6; claim from tgt1 in the next cycle returns 0. Complete(src 6, tgt1) ignored; complete(src 6, tgt0) -> IDLE. With irq_src[6] held high, int_pending[6]=1 two cycles after the complete.
- Claim source 2, disable it on tgt0, then complete(2, tgt0) -> ignored; the source stays IN_SERVICE and irq_src[2] edges do not set pending. Re-enable and complete -> IDLE.
- Assert rst_n=0 mid-service with sources 1 and 8 pending and 5 in service -> int_pending, irq_tgt and claim_src are all 0 immediately. After release, held irq lines re-pend in 1 cycle.

Source files
------------

// File: rtl/plic_pkg.sv
// Shared widths, ID type and gateway state encoding for the PLIC gateway/claim logic.
package plic_pkg;

    localparam int PLIC_ID_W    = 5;
    localparam int PLIC_MAX_SRC = 31;
    localparam int PLIC_MAX_TGT = 32;

    typedef logic [PLIC_ID_W-1:0] plic_id_t;

    typedef enum logic [1:0] {
        GW_IDLE       = 2'd0,
        GW_PENDING    = 2'd1,
        GW_IN_SERVICE = 2'd2
    } gw_state_e;

endpackage

// File: rtl/plic_gateway.sv
// One interrupt source gateway: latches a level request into a single pending
// request, holds the gate closed while in service and remembers the claiming target.
module plic_gateway
    import plic_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     irq,
    input  logic     claim_hit,
    input  plic_id_t claim_tgt,
    input  logic     complete_hit,
    input  plic_id_t complete_tgt,
    input  logic     complete_en,
    output logic     pending
);

    gw_state_e state_q;
    plic_id_t  owner_q;
    logic      pending_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= GW_IDLE;
            owner_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            case (state_q)
                GW_IDLE: begin
                    if (irq) begin
                        state_q   <= GW_PENDING;
                        pending_q <= 1'b1;
                    end
                end
                GW_PENDING: begin
                    if (claim_hit) begin
                        state_q   <= GW_IN_SERVICE;
                        pending_q <= 1'b0;
                        owner_q   <= claim_tgt;
                    end
                end
                GW_IN_SERVICE: begin
                    // Only the owning target may complete, and only while it still enables us.
                    if (complete_hit && (complete_tgt == owner_q) && complete_en) begin
                        state_q <= GW_IDLE;
                    end
                end
                default: begin
                    state_q   <= GW_IDLE;
                    pending_q <= 1'b0;
                end
            endcase
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/plic_gateway_ctrl.sv
// PLIC gateways plus per-target best-source selection, interrupt lines and
// claim/complete sequencing between the register block and the sources.
module plic_gateway_ctrl
    import plic_pkg::*;
#(
    parameter int SRC_N  = 31,
    parameter int TGT_N  = 2,
    parameter int PRIO_W = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [SRC_N:1]                  irq_src,
    input  logic                            claim_valid,
    input  plic_id_t                        claim_tgt,
    input  logic                            complete_valid,
    input  plic_id_t                        complete_src,
    input  plic_id_t                        complete_tgt,
    input  logic [SRC_N:0][PRIO_W-1:0]      cfg_int_prio,
    input  logic [TGT_N-1:0][SRC_N:0]       cfg_int_enable,
    input  logic [TGT_N-1:0][PRIO_W-1:0]    cfg_threshold,
    output logic [SRC_N:0]                  int_pending,
    output plic_id_t                        claim_src,
    output logic [TGT_N-1:0]                irq_tgt
);

    plic_id_t          best_id_d   [TGT_N];
    plic_id_t          best_id_q   [TGT_N];
    logic [PRIO_W-1:0] best_prio_d [TGT_N];
    logic [PRIO_W-1:0] best_prio_q [TGT_N];
    logic [TGT_N-1:0]  irq_d;
    logic [TGT_N-1:0]  irq_q;
    logic [SRC_N:1]    cmp_en;
    plic_id_t          sel_id;
    logic              sel_live;

    assign int_pending[0] = 1'b0;

    for (genvar i = 1; i <= SRC_N; i++) begin : g_gw
        plic_gateway u_gw (
            .clk          (clk),
            .rst_n        (rst_n),
            .irq          (irq_src[i]),
            .claim_hit    (claim_valid && (claim_src == PLIC_ID_W'(i))),
            .claim_tgt    (claim_tgt),
            .complete_hit (complete_valid && (complete_src == PLIC_ID_W'(i))),
            .complete_tgt (complete_tgt),
            .complete_en  (cmp_en[i]),
            .pending      (int_pending[i])
        );
    end

    // Enable row of the completing target; out-of-range targets leave it all zero.
    always_comb begin
        cmp_en = '0;
        for (int t = 0; t < TGT_N; t++) begin
            if (complete_tgt == PLIC_ID_W'(t)) begin
                cmp_en = cfg_int_enable[t][SRC_N:1];
            end
        end
    end

    // Strict compare while scanning upward keeps the lowest ID on priority ties.
    always_comb begin
        for (int t = 0; t < TGT_N; t++) begin
            best_id_d[t]   = '0;
            best_prio_d[t] = '0;
            for (int i = 0; i <= SRC_N; i++) begin
                if (int_pending[i] && cfg_int_enable[t][i] && (cfg_int_prio[i] != '0) &&
                    (cfg_int_prio[i] > best_prio_d[t])) begin
                    best_id_d[t]   = PLIC_ID_W'(i);
                    best_prio_d[t] = cfg_int_prio[i];
                end
            end
            irq_d[t] = (best_prio_d[t] > cfg_threshold[t]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < TGT_N; t++) begin
                best_id_q[t]   <= '0;
                best_prio_q[t] <= '0;
            end
            irq_q <= '0;
        end else begin
            for (int t = 0; t < TGT_N; t++) begin
                best_id_q[t]   <= best_id_d[t];
                best_prio_q[t] <= best_prio_d[t];
            end
            irq_q <= irq_d;
        end
    end

    assign irq_tgt = irq_q;

    // A registered winner may already have been claimed by another target; re-check pending.
    always_comb begin
        sel_id   = '0;
        sel_live = 1'b0;
        for (int t = 0; t < TGT_N; t++) begin
            if (claim_tgt == PLIC_ID_W'(t)) begin
                sel_id   = best_id_q[t];
                sel_live = (best_prio_q[t] != '0);
            end
        end
        claim_src = '0;
        for (int i = 1; i <= SRC_N; i++) begin
            if (sel_live && (sel_id == PLIC_ID_W'(i)) && int_pending[i]) begin
                claim_src = sel_id;
            end
        end
    end

endmodule

// File: tb/tb_plic_gateway_ctrl.sv
// Directed bench for plic_gateway_ctrl with a per-source behavioural model checked every cycle.
module tb_plic_gateway_ctrl;

    localparam int SRC_N  = 31;
    localparam int TGT_N  = 2;
    localparam int PRIO_W = 3;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic [SRC_N:1]               irq_src = '0;
    logic                         claim_valid = 1'b0;
    logic [4:0]                   claim_tgt = '0;
    logic                         complete_valid = 1'b0;
    logic [4:0]                   complete_src = '0;
    logic [4:0]                   complete_tgt = '0;
    logic [SRC_N:0][PRIO_W-1:0]   cfg_int_prio = '0;
    logic [TGT_N-1:0][SRC_N:0]    cfg_int_enable = '0;
    logic [TGT_N-1:0][PRIO_W-1:0] cfg_threshold = '0;
    logic [SRC_N:0]               int_pending;
    logic [4:0]                   claim_src;
    logic [TGT_N-1:0]             irq_tgt;

    int n_chk  = 0;
    int n_fail = 0;
    bit run    = 1'b0;

    plic_gateway_ctrl #(.SRC_N(SRC_N), .TGT_N(TGT_N), .PRIO_W(PRIO_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .irq_src        (irq_src),
        .claim_valid    (claim_valid),
        .claim_tgt      (claim_tgt),
        .complete_valid (complete_valid),
        .complete_src   (complete_src),
        .complete_tgt   (complete_tgt),
        .cfg_int_prio   (cfg_int_prio),
        .cfg_int_enable (cfg_int_enable),
        .cfg_threshold  (cfg_threshold),
        .int_pending    (int_pending),
        .claim_src      (claim_src),
        .irq_tgt        (irq_tgt)
    );

    always #5 clk = ~clk;

    // Model: per source 0 = idle, 1 = waiting to be claimed, 2 = being serviced.
    int m_st   [32];
    int m_own  [32];
    int m_best [TGT_N];
    bit m_irq  [TGT_N];
    int mc;
    int mnb    [TGT_N];
    logic [31:0] exp_pend;

    function automatic int m_pick(int t);
        for (int pr = 7; pr >= 1; pr--)
            for (int i = 1; i <= SRC_N; i++)
                if (m_st[i] == 1 && cfg_int_enable[t][i] && int'(cfg_int_prio[i]) == pr)
                    return i;
        return 0;
    endfunction

    function automatic int m_claim();
        int id;
        if (int'(claim_tgt) >= TGT_N) return 0;
        id = m_best[claim_tgt];
        if (id != 0 && m_st[id] == 1) return id;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_st[i]  = 0;
                m_own[i] = 0;
            end
            for (int t = 0; t < TGT_N; t++) begin
                m_best[t] = 0;
                m_irq[t]  = 1'b0;
            end
        end else begin
            mc = claim_valid ? m_claim() : 0;
            for (int t = 0; t < TGT_N; t++) mnb[t] = m_pick(t);
            for (int i = 1; i <= SRC_N; i++) begin
                if (m_st[i] == 0) begin
                    if (irq_src[i]) m_st[i] = 1;
                end else if (m_st[i] == 1) begin
                    if (mc == i) begin
                        m_st[i]  = 2;
                        m_own[i] = int'(claim_tgt);
                    end
                end else begin
                    if (complete_valid && int'(complete_src) == i && int'(complete_tgt) < TGT_N &&
                        int'(complete_tgt) == m_own[i] && cfg_int_enable[complete_tgt[0]][i])
                        m_st[i] = 0;
                end
            end
            for (int t = 0; t < TGT_N; t++) begin
                m_best[t] = mnb[t];
                m_irq[t]  = (mnb[t] != 0) && (cfg_int_prio[mnb[t]] > cfg_threshold[t]);
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            for (int i = 0; i < 32; i++) exp_pend[i] = (m_st[i] == 1);
            chk("model_int_pending", int_pending, exp_pend);
            chk("model_irq_tgt", {30'd0, irq_tgt}, {30'd0, m_irq[1], m_irq[0]});
            chk("model_claim_src", {27'd0, claim_src}, m_claim());
        end
    end

    always @(posedge clk) begin
        if (rst_n && claim_valid && complete_valid) begin
            n_fail++;
            $display("FAIL claim_complete_exclusive: actual both required one");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(int s);
        irq_src[s] = 1'b1;
        tick();
        irq_src[s] = 1'b0;
        tick();
    endtask

    task automatic claim_once(int tgt, int exp);
        claim_valid = 1'b1;
        claim_tgt   = 5'(tgt);
        @(negedge clk);
        chk("claim_value", {27'd0, claim_src}, exp);
        tick();
        claim_valid = 1'b0;
        claim_tgt   = '0;
        @(negedge clk);
        if (exp != 0) chk("claimed_pending_clear", {31'd0, int_pending[exp]}, 0);
        tick();
    endtask

    task automatic complete_once(int s, int t);
        complete_valid = 1'b1;
        complete_src   = 5'(s);
        complete_tgt   = 5'(t);
        tick();
        complete_valid = 1'b0;
        complete_src   = '0;
        complete_tgt   = '0;
    endtask

    initial begin
        cfg_int_prio[5]  = 3'd3;
        cfg_int_prio[3]  = 3'd2;
        cfg_int_prio[7]  = 3'd2;
        cfg_int_prio[9]  = 3'd1;
        cfg_int_prio[4]  = 3'd1;
        cfg_int_prio[6]  = 3'd4;
        cfg_int_prio[2]  = 3'd5;
        cfg_int_prio[1]  = 3'd2;
        cfg_int_prio[8]  = 3'd3;
        cfg_int_prio[10] = 3'd0;
        repeat (2) @(posedge clk);
        run = 1'b1;
        #1;
        @(negedge clk);
        chk("reset_pending", int_pending, 0);
        chk("reset_irq", {30'd0, irq_tgt}, 0);
        chk("reset_claim", {27'd0, claim_src}, 0);
        tick();
        rst_n = 1'b1;

        // Single pulse latches, selection follows one cycle later.
        cfg_int_enable[0][5] = 1'b1;
        irq_src[5] = 1'b1;
        tick();
        irq_src[5] = 1'b0;
        @(negedge clk);
        chk("t1_pending_rise", {31'd0, int_pending[5]}, 1);
        chk("t1_irq_not_yet", {30'd0, irq_tgt}, 0);
        tick();
        @(negedge clk);
        chk("t1_pending_held", {31'd0, int_pending[5]}, 1);
        chk("t1_irq_tgt0_only", {30'd0, irq_tgt}, 2'b01);
        chk("t1_claim_peek", {27'd0, claim_src}, 5);
        tick();
        claim_once(0, 5);
        complete_once(5, 0);
        cfg_int_enable[0][5] = 1'b0;

        // Priority order with lowest-ID tie break.
        cfg_int_enable[0][3] = 1'b1;
        cfg_int_enable[0][7] = 1'b1;
        cfg_int_enable[0][9] = 1'b1;
        irq_src[3] = 1'b1; irq_src[7] = 1'b1; irq_src[9] = 1'b1;
        tick();
        irq_src[3] = 1'b0; irq_src[7] = 1'b0; irq_src[9] = 1'b0;
        tick();
        @(negedge clk);
        chk("t2_pending_set", int_pending, 32'h0000_0288);
        tick();
        claim_once(0, 3);
        claim_once(0, 7);
        claim_once(0, 9);
        complete_once(3, 0);
        complete_once(7, 0);
        complete_once(9, 0);
        cfg_int_enable[0] = '0;

        // Threshold gates irq_tgt but not claim; out-of-range claim target is inert.
        cfg_int_enable[0][4] = 1'b1;
        cfg_threshold[0]     = 3'd1;
        pulse(4);
        @(negedge clk);
        chk("t3_irq_masked", {30'd0, irq_tgt}, 0);
        chk("t3_claim_visible", {27'd0, claim_src}, 4);
        tick();
        claim_valid = 1'b1;
        claim_tgt   = 5'd5;
        @(negedge clk);
        chk("t3_claim_bad_tgt", {27'd0, claim_src}, 0);
        tick();
        claim_valid = 1'b0;
        claim_tgt   = '0;
        cfg_threshold[0] = 3'd0;
        @(negedge clk);
        chk("t3_pending_kept", {31'd0, int_pending[4]}, 1);
        chk("t3_irq_before", {30'd0, irq_tgt}, 0);
        tick();
        @(negedge clk);
        chk("t3_irq_after", {30'd0, irq_tgt}, 2'b01);
        tick();
        claim_once(0, 4);
        complete_once(4, 0);
        cfg_int_enable[0][4] = 1'b0;

        // Two targets race for one source; only the owner completes.
        cfg_int_enable[0][6] = 1'b1;
        cfg_int_enable[1][6] = 1'b1;
        irq_src[6] = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("t4_irq_both", {30'd0, irq_tgt}, 2'b11);
        tick();
        claim_valid = 1'b1;
        claim_tgt   = 5'd0;
        @(negedge clk);
        chk("t4_claim_tgt0", {27'd0, claim_src}, 6);
        tick();
        claim_tgt = 5'd1;
        @(negedge clk);
        chk("t4_claim_tgt1_stale", {27'd0, claim_src}, 0);
        tick();
        claim_valid = 1'b0;
        claim_tgt   = '0;
        complete_once(6, 1);
        complete_once(6, 2);
        complete_once(0, 0);
        @(negedge clk);
        chk("t4_wrong_complete", {31'd0, int_pending[6]}, 0);
        tick();
        complete_once(6, 0);
        @(negedge clk);
        chk("t4_rearm_1cyc", {31'd0, int_pending[6]}, 0);
        tick();
        @(negedge clk);
        chk("t4_rearm_2cyc", {31'd0, int_pending[6]}, 1);
        irq_src[6] = 1'b0;
        tick();
        claim_once(0, 6);
        complete_once(6, 0);
        cfg_int_enable[0][6] = 1'b0;
        cfg_int_enable[1][6] = 1'b0;

        // Complete is refused while the owner has the source disabled.
        cfg_int_enable[0][2] = 1'b1;
        pulse(2);
        claim_once(0, 2);
        cfg_int_enable[0][2] = 1'b0;
        complete_once(2, 0);
        pulse(2);
        @(negedge clk);
        chk("t5_gate_closed", {31'd0, int_pending[2]}, 0);
        tick();
        cfg_int_enable[0][2] = 1'b1;
        complete_once(2, 0);
        irq_src[2] = 1'b1;
        tick();
        @(negedge clk);
        chk("t5_reopened", {31'd0, int_pending[2]}, 1);
        irq_src[2] = 1'b0;
        tick();
        tick();
        claim_once(0, 2);
        complete_once(2, 0);
        cfg_int_enable[0][2] = 1'b0;

        // Priority 0 pends but never selects.
        cfg_int_enable[0][10] = 1'b1;
        pulse(10);
        @(negedge clk);
        chk("t6_prio0_pending", {31'd0, int_pending[10]}, 1);
        chk("t6_prio0_no_irq", {30'd0, irq_tgt}, 0);
        chk("t6_prio0_no_claim", {27'd0, claim_src}, 0);
        tick();

        // Asynchronous reset in the middle of service.
        cfg_int_enable[0][1] = 1'b1;
        cfg_int_enable[0][8] = 1'b1;
        cfg_int_enable[0][5] = 1'b1;
        pulse(5);
        claim_once(0, 5);
        irq_src[1] = 1'b1;
        irq_src[8] = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("t7_claim_best", {27'd0, claim_src}, 8);
        chk("t7_irq_pre", {30'd0, irq_tgt}, 2'b01);
        tick();
        rst_n = 1'b0;
        #1;
        chk("t7_rst_pending", int_pending, 0);
        chk("t7_rst_irq", {30'd0, irq_tgt}, 0);
        chk("t7_rst_claim", {27'd0, claim_src}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("t7_repend", int_pending, 32'h0000_0102);
        irq_src = '0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
